// File: rtl/seq_cmp.sv
// rtl/seq_cmp.sv - multi-cycle chunked magnitude comparator (unsigned/signed)
//
// Purpose:
//   Holds two operands A and B, which are loaded from a shared bus by separate
//   push strobes. On an accepted start, the block compares A and B CHUNK bits
//   per cycle, starting with the most significant chunk. It stops at the
//   first chunk that differs. The eq/lt/gt result is registered and held
//   until the next compare writes a new one.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   in       in   WIDTH  shared operand bus
//   push1    in   1      load in -> A, set valid1
//   push2    in   1      load in -> B, set valid2
//   start    in   1      request a compare (needs valid1 & valid2, idle only)
//   signed_m in   1      sampled with accepted start; 1 = two's-complement
//   valid1   out  1      A holds a pushed value
//   valid2   out  1      B holds a pushed value
//   busy     out  1      compare in progress (CMP or DONE)
//   done     out  1      one-cycle result-valid pulse
//   eq/lt/gt out  1      registered, held result flags

module seq_cmp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             push1,
  input  logic             push2,
  input  logic             start,
  input  logic             signed_m,
  output logic             valid1,
  output logic             valid2,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] wa_q, wa_d, wb_q, wb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid1_q, valid1_d, valid2_q, valid2_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;

  // The working copies are shifted left after each equal chunk, so the chunk
  // under test is always the top CHUNK bits. idx only counts the chunks that
  // remain.
  logic [CHUNK-1:0] ca, cb;
  assign ca = wa_q[WIDTH-1 -: CHUNK];
  assign cb = wb_q[WIDTH-1 -: CHUNK];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    idx_d    = idx_q;
    valid1_d = valid1_q;
    valid2_d = valid2_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    gt_d     = gt_q;

    case (state_q)
      ST_IDLE: begin
        if (start && valid1_q && valid2_q) begin
          // Flipping the sign bit maps two's complement onto offset binary.
          // After that, an unsigned compare gives the signed ordering.
          wa_d    = signed_m ? (a_q ^ MSB_MASK) : a_q;
          wb_d    = signed_m ? (b_q ^ MSB_MASK) : b_q;
          idx_d   = IW'(N - 1);
          state_d = ST_CMP;
        end else begin
          if (push1) begin
            a_d      = in;
            valid1_d = 1'b1;
          end
          if (push2) begin
            b_d      = in;
            valid2_d = 1'b1;
          end
        end
      end
      ST_CMP: begin
        if (ca != cb) begin
          gt_d    = (ca > cb);
          lt_d    = (ca < cb);
          eq_d    = 1'b0;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
          wa_d  = wa_q << CHUNK;
          wb_d  = wb_q << CHUNK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      idx_q    <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      idx_q    <= idx_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
    end
  end

  assign valid1 = valid1_q;
  assign valid2 = valid2_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign eq     = eq_q;
  assign lt     = lt_q;
  assign gt     = gt_q;

endmodule

// File: tb/tb_seq_cmp.sv
// tb/tb_seq_cmp.sv - directed self-checking bench for seq_cmp
module tb_seq_cmp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_bus = '0;
  logic        push1 = 1'b0, push2 = 1'b0, start = 1'b0, signed_m = 1'b0;
  logic        valid1, valid2, busy, done, eq, lt, gt;

  int tests = 0;
  int fails = 0;
  int n;
  int seen_done;

  seq_cmp #(.WIDTH(16), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in(in_bus), .push1(push1), .push2(push2),
    .start(start), .signed_m(signed_m), .valid1(valid1), .valid2(valid2),
    .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic p1, input logic p2, input logic [15:0] v);
    push1  = p1;
    push2  = p2;
    in_bus = v;
    step();
    push1  = 1'b0;
    push2  = 1'b0;
  endtask

  task automatic do_start(input logic sm);
    start    = 1'b1;
    signed_m = sm;
    step();
    start    = 1'b0;
    signed_m = 1'b0;
  endtask

  // Counts edges after the start edge until done rises. The count is bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 20) begin
      step();
      cnt++;
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic l, input logic g);
    check({tag, "_eq"}, {31'd0, eq}, {31'd0, e});
    check({tag, "_lt"}, {31'd0, lt}, {31'd0, l});
    check({tag, "_gt"}, {31'd0, gt}, {31'd0, g});
  endtask

  initial begin
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_v1", {31'd0, valid1}, 32'd0);
    check("rst_v2", {31'd0, valid2}, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Start with only A valid is ignored.
    do_push(1'b1, 1'b0, 16'h1234);
    check("t4_v1", {31'd0, valid1}, 32'd1);
    check("t4_v2", {31'd0, valid2}, 32'd0);
    do_start(1'b0);
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      check("t4_busy", {31'd0, busy}, 32'd0);
      if (done) seen_done = 1;
      step();
    end
    check("t4_nodone", seen_done, 0);
    check_flags("t4", 1'b0, 1'b0, 1'b0);

    // Equal operands: all 8 chunks are examined.
    do_push(1'b1, 1'b0, 16'h1234);
    do_push(1'b0, 1'b1, 16'h1234);
    do_start(1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("t1_lat", n, 8);
    check_flags("t1", 1'b1, 1'b0, 1'b0);
    // A start during DONE is ignored, and the block returns to idle.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_done_start_busy", {31'd0, busy}, 32'd0);
    step();
    check("t1_done_start_busy2", {31'd0, busy}, 32'd0);

    // 0x8000 vs 0x7FFF, first unsigned and then signed.
    do_push(1'b1, 1'b0, 16'h8000);
    do_push(1'b0, 1'b1, 16'h7FFF);
    do_start(1'b0);
    check("t2u_hold_eq", {31'd0, eq}, 32'd1);
    wait_done(n);
    check("t2u_lat", n, 1);
    check_flags("t2u", 1'b0, 1'b0, 1'b1);
    step();
    do_start(1'b1);
    check("t2s_hold_gt", {31'd0, gt}, 32'd1);
    wait_done(n);
    check("t2s_lat", n, 1);
    check_flags("t2s", 1'b0, 1'b1, 1'b0);
    step();

    // The operands differ only in chunk 0. Both pushes happen in the same cycle.
    do_push(1'b1, 1'b1, 16'h00F0);
    do_push(1'b0, 1'b1, 16'h00F1);
    do_start(1'b0);
    wait_done(n);
    check("t3_lat", n, 8);
    check_flags("t3", 1'b0, 1'b1, 1'b0);
    step();
    // A push that arrives with an accepted start is dropped, so the result stays lt.
    push1  = 1'b1;
    in_bus = 16'hFFFF;
    do_start(1'b0);
    push1  = 1'b0;
    wait_done(n);
    check_flags("t3p", 1'b0, 1'b1, 1'b0);
    step();

    // A push during CMP is ignored, and the operands can be compared again.
    do_push(1'b1, 1'b0, 16'h0001);
    do_push(1'b0, 1'b1, 16'h0002);
    do_start(1'b0);
    step();
    do_push(1'b0, 1'b1, 16'h0000);
    check("t5_v2", {31'd0, valid2}, 32'd1);
    wait_done(n);
    check("t5_lat", n, 6);
    check_flags("t5", 1'b0, 1'b1, 1'b0);
    step();
    do_start(1'b0);
    wait_done(n);
    check("t5b_lat", n, 8);
    check_flags("t5b", 1'b0, 1'b1, 1'b0);
    step();

    // An asynchronous reset in the middle of CMP.
    do_push(1'b1, 1'b1, 16'hABCD);
    do_start(1'b0);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_v1", {31'd0, valid1}, 32'd0);
    check("t6_v2", {31'd0, valid2}, 32'd0);
    check_flags("t6", 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen_done = 1;
      step();
    end
    check("t6_nodone", seen_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
